// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled serial receive with one-word transmit buffer.
// Define SPI_SLAVE_OVERRUN_EN to enable the sticky rx_overrun flag.
module spi_slave_rx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ack,
   output logic              frame_err,
   output logic              rx_overrun
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam int FW = $clog2(SYNC_STAGES + 1);

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;

   logic sclk_s;
   logic cs_s;
   logic mosi_s;
   logic sclk_prev;
   logic cs_prev;

   logic [FW-1:0] flush_cnt;
   logic          settled;
   logic          armed;

   logic sclk_rise;
   logic sclk_fall;
   logic cs_fall;
   logic cs_rise;

   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     cnt_inc;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] hold_q;
   logic              hold_full;

   logic start;
   logic stop;
   logic bit_rise;
   logic frame_done;
   logic load_tx;
   logic shift_tx;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // A falling cs_n only counts once cs_n has been seen high on real
   // samples, so a select held low across reset never starts a frame.
   assign settled   = (flush_cnt == FW'(SYNC_STAGES));
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_fall   = armed & cs_prev & ~cs_s;
   assign cs_rise   = cs_s & ~cs_prev;

   assign cnt_inc = bit_cnt + CW'(1);
   assign rx_next = {rx_shift[DATA_W-2:0], mosi_s};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      start      = 1'b0;
      stop       = 1'b0;
      bit_rise   = 1'b0;
      frame_done = 1'b0;
      shift_tx   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = ACTIVE;
               start   = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_rise) begin
               state_d = IDLE;
               stop    = 1'b1;
            end else begin
               bit_rise   = sclk_rise;
               frame_done = sclk_rise && (cnt_inc == CW'(DATA_W));
               // The fall after a completed frame must not shift out the
               // freshly loaded MSB; bit_cnt is 0 exactly then.
               shift_tx   = sclk_fall && (bit_cnt != '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign load_tx = start | frame_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
         flush_cnt <= '0;
         armed     <= 1'b0;
      end else begin
         sclk_sync[0] <= sclk;
         cs_sync[0]   <= cs_n;
         mosi_sync[0] <= mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sclk_sync[i] <= sclk_sync[i-1];
            cs_sync[i]   <= cs_sync[i-1];
            mosi_sync[i] <= mosi_sync[i-1];
         end
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
         if (!settled) begin
            flush_cnt <= flush_cnt + FW'(1);
         end
         if (settled && cs_s) begin
            armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         hold_q    <= '0;
         hold_full <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (load_tx) begin
            tx_shift  <= hold_full ? hold_q : '0;
            hold_full <= 1'b0;
         end else if (shift_tx) begin
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
         end
         if (tx_valid && !hold_full) begin
            hold_q    <= tx_data;
            hold_full <= 1'b1;
         end
         if (start || stop) begin
            bit_cnt <= '0;
         end else if (bit_rise) begin
            bit_cnt <= frame_done ? '0 : cnt_inc;
         end
         if (bit_rise) begin
            rx_shift <= rx_next;
         end
         if (frame_done) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
         frame_err <= stop && (bit_cnt != '0);
      end
   end

`ifdef SPI_SLAVE_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_overrun <= 1'b0;
      end else if (frame_done && rx_valid && !rx_ack) begin
         rx_overrun <= 1'b1;
      end
   end
`else
   assign rx_overrun = 1'b0;
`endif

   assign miso     = (state_q == ACTIVE) & tx_shift[DATA_W-1];
   assign miso_oe  = (state_q == ACTIVE);
   assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: mode-0 master at clk/8.
// Overrun expectation follows SPI_SLAVE_OVERRUN_EN.
module tb_spi_slave_rx;

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic       sclk     = 1'b0;
   logic       cs_n     = 1'b1;
   logic       mosi     = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       rx_ack   = 1'b0;

   logic       miso;
   logic       miso_oe;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_overrun;

`ifdef SPI_SLAVE_OVERRUN_EN
   localparam logic OVR = 1'b1;
`else
   localparam logic OVR = 1'b0;
`endif

   int n_chk   = 0;
   int n_pass  = 0;
   int ferr_n  = 0;
   int txr_low = 0;
   int base;
   logic [7:0] got;

   spi_slave_rx #(
      .DATA_W     (8),
      .SYNC_STAGES(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ack    (rx_ack),
      .frame_err (frame_err),
      .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) ferr_n++;
      if (!tx_ready) txr_low++;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic half();
      clks(4);
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      half();
   endtask

   task automatic cs_high();
      cs_n = 1'b1;
      clks(8);
   endtask

   task automatic push(input logic [7:0] v);
      tx_data  = v;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic ack();
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] w, input int nbits,
                       output logic [7:0] cap);
      cap = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = w[7-i];
         half();
         cap  = {cap[6:0], miso};
         sclk = 1'b1;
         half();
         sclk = 1'b0;
      end
      half();
   endtask

   initial begin
      clks(3);
      check("rst_miso", miso, 0);
      check("rst_oe", miso_oe, 0);
      check("rst_txr", tx_ready, 1);
      check("rst_rxd", rx_data, 0);
      check("rst_rxv", rx_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", rx_overrun, 0);
      rst = 1'b0;
      clks(5);

      // single frame, A5 out / 3C in
      push(8'hA5);
      check("txr_full", tx_ready, 0);
      cs_low();
      check("oe_act", miso_oe, 1);
      check("miso_msb", miso, 1);
      check("txr_load", tx_ready, 1);
      xfer(8'h3C, 8, got);
      check("miso_word", got, 8'hA5);
      check("rxv_1", rx_valid, 1);
      check("rxd_1", rx_data, 8'h3C);
      ack();
      check("rxv_ack", rx_valid, 0);
      cs_high();
      check("oe_idle", miso_oe, 0);
      check("miso_idle", miso, 0);

      // back-to-back frames without deselect
      base = ferr_n;
      cs_low();
      xfer(8'h01, 8, got);
      check("b2b_v0", rx_valid, 1);
      check("b2b_d0", rx_data, 8'h01);
      ack();
      check("b2b_a0", rx_valid, 0);
      xfer(8'hFE, 8, got);
      check("b2b_v1", rx_valid, 1);
      check("b2b_d1", rx_data, 8'hFE);
      ack();
      cs_high();
      check("b2b_ferr", ferr_n - base, 0);

      // partial frame then full frame
      base = ferr_n;
      cs_low();
      xfer(8'hA0, 3, got);
      cs_high();
      check("part_ferr", ferr_n - base, 1);
      check("part_rxv", rx_valid, 0);
      check("part_rxd", rx_data, 8'hFE);
      cs_low();
      xfer(8'h55, 8, got);
      cs_high();
      check("after_v", rx_valid, 1);
      check("after_d", rx_data, 8'h55);
      ack();

      // no transmit word loaded
      base = txr_low;
      cs_low();
      xfer(8'hAA, 8, got);
      cs_high();
      check("empty_miso", got, 8'h00);
      check("empty_txr", txr_low - base, 0);
      check("empty_rxd", rx_data, 8'hAA);
      ack();

      // two frames, no ack
      cs_low();
      xfer(8'h11, 8, got);
      xfer(8'h22, 8, got);
      cs_high();
      check("ovr_rxd", rx_data, 8'h22);
      check("ovr_rxv", rx_valid, 1);
      check("ovr_flag", rx_overrun, OVR);
      ack();
      check("ovr_stick", rx_overrun, OVR);
      rst = 1'b1;
      clks(2);
      check("ovr_rst", rx_overrun, 0);
      rst = 1'b0;
      clks(4);

      // reset mid-frame
      base = ferr_n;
      cs_low();
      xfer(8'hC3, 2, got);
      rst = 1'b1;
      clks(2);
      rst = 1'b0;
      clks(8);
      check("mrst_oe", miso_oe, 0);
      check("mrst_miso", miso, 0);
      check("mrst_txr", tx_ready, 1);
      check("mrst_rxd", rx_data, 0);
      check("mrst_rxv", rx_valid, 0);
      check("mrst_ovr", rx_overrun, 0);
      cs_high();
      check("mrst_ferr", ferr_n - base, 0);
      cs_low();
      xfer(8'h96, 8, got);
      cs_high();
      check("mrst_v", rx_valid, 1);
      check("mrst_d", rx_data, 8'h96);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
